fb_ram_reader: RTL

//  Read-side streamer for the frame-buffer RAM (combinational read port). On start it walks
//  RAM addresses 0..FRAME_WORDS-1, holds up to two fetched words and unpacks each into
//  PIX_PER_WORD pixels on a valid/ready stream to the VGA pixel path; ends with a done pulse.

---
 rtl/fb_ram_reader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fb_ram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fb_ram_reader
//  Brief    : Frame-buffer RAM read streamer. Walks the frame, double-buffers
//             fetched words and unpacks them LSB-first onto a pixel stream.
//  Revision : 1.0 - initial release
// ============================================================================
module fb_ram_reader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int PIX_BITS    = 4,
  parameter int FRAME_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [PIX_BITS-1:0]   pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  done
);

  localparam int c_PIX_PER_WORD = DATA_WIDTH / PIX_BITS;
  localparam int c_SLICE_W      = (c_PIX_PER_WORD > 1) ? $clog2(c_PIX_PER_WORD) : 1;
  localparam logic [c_SLICE_W-1:0]  c_LAST_SLICE = c_SLICE_W'(c_PIX_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR  = ADDR_WIDTH'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic [c_SLICE_W-1:0]  r_slice;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_done;

  logic                  w_busy;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_last_pix;
  logic                  w_final;
  logic                  w_flush;
  logic                  w_cap;
  logic                  w_tail;
  logic [DATA_WIDTH-1:0] w_head_word;

  assign w_busy      = (r_state != S_IDLE);
  assign pix_valid   = (r_count != 2'd0);
  assign w_hs        = pix_valid & pix_ready;
  assign w_pop       = w_hs & (r_slice == c_LAST_SLICE);
  // Once in DRAIN every word is buffered, so the lone remaining word is the last one.
  assign w_last_pix  = pix_valid & (r_state == S_DRAIN) & (r_count == 2'd1) &
                       (r_slice == c_LAST_SLICE);
  assign w_final     = w_hs & w_last_pix;
  assign w_flush     = abort & w_busy;
  // A popping head frees its entry in the same cycle, allowing capture into a full buffer.
  assign w_cap       = (r_state == S_RUN) & ~abort & ((r_count != 2'd2) | w_pop);
  assign w_tail      = r_head ^ r_count[0];
  assign w_head_word = r_buf[r_head];

  assign read_addr = r_addr;
  assign pix_last  = w_last_pix;
  assign busy      = w_busy;
  assign done      = r_done;

  always_comb begin
    pix_data = '0;
    if (pix_valid) begin
      for (int i = 0; i < c_PIX_PER_WORD; i++) begin
        if (r_slice == c_SLICE_W'(i)) pix_data = w_head_word[i*PIX_BITS +: PIX_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !abort) w_state_next = S_RUN;
      S_RUN: begin
        if (abort)                                w_state_next = S_IDLE;
        else if (w_cap && (r_addr == c_LAST_ADDR)) w_state_next = S_DRAIN;
      end
      S_DRAIN: if (abort || w_final) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
      r_slice  <= '0;
      r_addr   <= '0;
      r_done   <= 1'b0;
    end else if (w_flush) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
      r_slice <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_cap) r_buf[w_tail] <= read_data;
      if (w_hs)  r_slice <= w_pop ? '0 : r_slice + c_SLICE_W'(1);
      if (w_pop) r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_cap} - {1'b0, w_pop};
      if (w_state_next == S_IDLE)
        r_addr <= '0;
      else if (w_cap && (r_addr != c_LAST_ADDR))
        r_addr <= r_addr + ADDR_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire
